// File: rtl/muldiv_unit_if.sv
// muldiv_unit_if
// Handshake and result bundle between the EX stage and the multiply/divide unit.
//   master (EX stage) : drives start, op, a, b, annul; observes busy, done, hi, lo, div_by_zero
//   slave  (muldiv)   : the reverse
interface muldiv_unit_if #(
   parameter int WIDTH = 32
);
   logic             start;
   logic [1:0]       op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             annul;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;
   logic             div_by_zero;

   modport master (
      output start, op, a, b, annul,
      input  busy, done, hi, lo, div_by_zero
   );

   modport slave (
      input  start, op, a, b, annul,
      output busy, done, hi, lo, div_by_zero
   );
endinterface

// File: rtl/muldiv_unit.sv
// muldiv_unit
// Multi-cycle MULT/MULTU/DIV/DIVU unit. Operands are captured on an accepted
// start; the double-width result is presented on hi/lo with a one-cycle done.
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : muldiv_unit_if.slave (start/op/a/b/annul in; busy/done/hi/lo/div_by_zero out)
// Parameters:
//   WIDTH         : operand width (even, >= 8)
//   MUL_ITERATIVE : 0 = registered combinational product, 1 = shift-add
//
// state  | meaning
// IDLE   | waiting for start
// CALC   | one divide/multiply iteration per edge
// FIX    | sign correction, loads hi/lo
// DONE   | result presented, done high for one cycle
module muldiv_unit #(
   parameter int WIDTH         = 32,
   parameter bit MUL_ITERATIVE = 1'b0
) (
   input  logic            clk,
   input  logic            rst,
   muldiv_unit_if.slave    bus
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_FIX  = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t             r_state;
   state_t             w_next;
   logic               w_accept;

   logic               r_is_div;
   logic               r_sign_q;
   logic               r_sign_r;
   logic [WIDTH-1:0]   r_ma;
   logic [WIDTH-1:0]   r_mb;
   logic [CW-1:0]      r_cnt;
   logic [2*WIDTH-1:0] r_acc;
   logic [WIDTH-1:0]   r_hi;
   logic [WIDTH-1:0]   r_lo;
   logic               r_dbz;
   logic               r_busy;
   logic               r_done;

   // operand conditioning at start
   logic               w_signed;
   logic               w_b_zero;
   logic [WIDTH-1:0]   w_ma;
   logic [WIDTH-1:0]   w_mb;
   logic [2*WIDTH-1:0] w_ax;
   logic [2*WIDTH-1:0] w_bx;
   logic [2*WIDTH-1:0] w_prod;

   assign w_signed = ~bus.op[0];
   assign w_b_zero = (bus.b == '0);
   assign w_ma     = (w_signed && bus.a[WIDTH-1]) ? -bus.a : bus.a;
   assign w_mb     = (w_signed && bus.b[WIDTH-1]) ? -bus.b : bus.b;
   // Extending to 2*WIDTH (sign or zero) makes the truncated product exact
   // for both MULT and MULTU.
   assign w_ax     = {{WIDTH{w_signed & bus.a[WIDTH-1]}}, bus.a};
   assign w_bx     = {{WIDTH{w_signed & bus.b[WIDTH-1]}}, bus.b};
   assign w_prod   = w_ax * w_bx;

   // restoring division step: r_acc = {partial remainder, dividend/quotient bits}
   logic [WIDTH:0]     w_part;
   logic               w_ge;
   logic [WIDTH-1:0]   w_diff;
   logic [2*WIDTH-1:0] w_div_next;

   assign w_part     = r_acc[2*WIDTH-1:WIDTH-1];
   assign w_ge       = (w_part >= {1'b0, r_mb});
   assign w_diff     = w_part[WIDTH-1:0] - r_mb;
   assign w_div_next = w_ge ? {w_diff, r_acc[WIDTH-2:0], 1'b1}
                            : {r_acc[2*WIDTH-2:0], 1'b0};

   // shift-add step: r_acc = {running sum, remaining multiplier bits}
   logic [WIDTH:0]     w_sum;
   logic [2*WIDTH-1:0] w_mul_next;

   assign w_sum      = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_ma} : '0);
   assign w_mul_next = {w_sum, r_acc[WIDTH-1:1]};

   // sign correction
   logic [WIDTH-1:0]   w_fix_hi;
   logic [WIDTH-1:0]   w_fix_lo;
   logic [2*WIDTH-1:0] w_fix_prod;

   assign w_fix_prod = r_sign_q ? -r_acc : r_acc;

   always_comb begin
      w_fix_hi = w_fix_prod[2*WIDTH-1:WIDTH];
      w_fix_lo = w_fix_prod[WIDTH-1:0];
      if (r_is_div) begin
         w_fix_lo = r_sign_q ? -r_acc[WIDTH-1:0]       : r_acc[WIDTH-1:0];
         w_fix_hi = r_sign_r ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];
      end
   end

   always_comb begin
      w_next   = r_state;
      w_accept = 1'b0;
      case (r_state)
         S_IDLE: begin
            // annul wins over start
            if (bus.start && !bus.annul) begin
               w_accept = 1'b1;
               if (bus.op[1] && w_b_zero)
                  w_next = S_DONE;
               else if (!bus.op[1] && !MUL_ITERATIVE)
                  w_next = S_DONE;
               else
                  w_next = S_CALC;
            end
         end
         S_CALC: begin
            if (bus.annul)
               w_next = S_IDLE;
            else if (r_cnt == CNT_LAST)
               w_next = S_FIX;
         end
         S_FIX: begin
            if (bus.annul)
               w_next = S_IDLE;
            else
               w_next = S_DONE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state  <= S_IDLE;
         r_is_div <= 1'b0;
         r_sign_q <= 1'b0;
         r_sign_r <= 1'b0;
         r_ma     <= '0;
         r_mb     <= '0;
         r_cnt    <= '0;
         r_acc    <= '0;
         r_hi     <= '0;
         r_lo     <= '0;
         r_dbz    <= 1'b0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
      end else begin
         r_state <= w_next;
         r_busy  <= (w_next != S_IDLE);
         r_done  <= (w_next == S_DONE);

         if (w_accept) begin
            r_is_div <= bus.op[1];
            r_sign_q <= w_signed & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
            r_sign_r <= w_signed & bus.a[WIDTH-1];
            r_ma     <= w_ma;
            r_mb     <= w_mb;
            r_cnt    <= '0;
            r_dbz    <= 1'b0;
            // dividend sits in the low half for divide, multiplier for multiply
            r_acc    <= {{WIDTH{1'b0}}, (bus.op[1] ? w_ma : w_mb)};
            if (bus.op[1] && w_b_zero) begin
               r_hi  <= bus.a;
               r_lo  <= '1;
               r_dbz <= 1'b1;
            end else if (!bus.op[1] && !MUL_ITERATIVE) begin
               r_hi  <= w_prod[2*WIDTH-1:WIDTH];
               r_lo  <= w_prod[WIDTH-1:0];
            end
         end

         if (r_state == S_CALC && !bus.annul) begin
            r_acc <= r_is_div ? w_div_next : w_mul_next;
            r_cnt <= r_cnt + CW'(1);
         end

         if (r_state == S_FIX && !bus.annul) begin
            r_hi <= w_fix_hi;
            r_lo <= w_fix_lo;
         end
      end
   end

   assign bus.busy        = r_busy;
   assign bus.done        = r_done;
   assign bus.hi          = r_hi;
   assign bus.lo          = r_lo;
   assign bus.div_by_zero = r_dbz;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit
// Drives a combinational-multiply instance and an iterative-multiply instance
// with identical stimulus and compares both against a plain-arithmetic model.
module tb_muldiv_unit;

   localparam int W = 32;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   muldiv_unit_if #(.WIDTH(W)) bus0 ();
   muldiv_unit_if #(.WIDTH(W)) bus1 ();

   muldiv_unit #(.WIDTH(W), .MUL_ITERATIVE(1'b0)) u_dut0 (
      .clk (clk),
      .rst (rst),
      .bus (bus0.slave)
   );

   muldiv_unit #(.WIDTH(W), .MUL_ITERATIVE(1'b1)) u_dut1 (
      .clk (clk),
      .rst (rst),
      .bus (bus1.slave)
   );

   int n_err = 0;
   int n_chk = 0;

   logic [W-1:0] last_hi;
   logic [W-1:0] last_lo;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic drive(input logic s, input logic [1:0] o, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic an);
      bus0.start = s;  bus1.start = s;
      bus0.op    = o;  bus1.op    = o;
      bus0.a     = a;  bus1.a     = a;
      bus0.b     = b;  bus1.b     = b;
      bus0.annul = an; bus1.annul = an;
   endtask

   // {div_by_zero, hi, lo}
   function automatic logic [2*W:0] model(input logic [1:0] op, input logic [W-1:0] a,
                                          input logic [W-1:0] b);
      longint sa, sb, q, r;
      logic [63:0] p;
      logic [2*W:0] res;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      res = '0;
      case (op)
         2'b00: begin
            q = sa * sb;
            res = {1'b0, q[63:0]};
         end
         2'b01: begin
            p = {32'b0, a} * {32'b0, b};
            res = {1'b0, p};
         end
         default: begin
            if (b == 0) begin
               res = {1'b1, a, {W{1'b1}}};
            end else if (op == 2'b10) begin
               q = sa / sb;
               r = sa % sb;
               res = {1'b0, r[W-1:0], q[W-1:0]};
            end else begin
               p[W-1:0] = a / b;
               p[63:W]  = a % b;
               res = {1'b0, p};
            end
         end
      endcase
      return res;
   endfunction

   task automatic run_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input bit noise);
      logic [2*W:0] e;
      int lat0, lat1, bsy0, bsy1, exp0, exp1;
      e    = model(op, a, b);
      lat0 = -1; lat1 = -1; bsy0 = 0; bsy1 = 0;
      exp1 = (op[1] && b == 0) ? 1 : W + 2;
      exp0 = (op[1] && b == 0) || !op[1] ? 1 : W + 2;
      drive(1'b1, op, a, b, 1'b0);
      for (int c = 1; c <= 80 && (lat0 < 0 || lat1 < 0); c++) begin
         @(posedge clk); #1;
         if (bus0.busy) bsy0++;
         if (bus1.busy) bsy1++;
         if (bus0.done && lat0 < 0) begin
            lat0 = c;
            check("hi0", {32'b0, bus0.hi}, {32'b0, e[2*W-1:W]});
            check("lo0", {32'b0, bus0.lo}, {32'b0, e[W-1:0]});
            check("dbz0", {63'b0, bus0.div_by_zero}, {63'b0, e[2*W]});
         end
         if (bus1.done && lat1 < 0) begin
            lat1 = c;
            check("hi1", {32'b0, bus1.hi}, {32'b0, e[2*W-1:W]});
            check("lo1", {32'b0, bus1.lo}, {32'b0, e[W-1:0]});
            check("dbz1", {63'b0, bus1.div_by_zero}, {63'b0, e[2*W]});
         end
         bus0.start = 1'b0; bus1.start = 1'b0;
         if (noise && (lat0 < 0 || lat1 < 0)) begin
            drive(1'b0, 2'($urandom_range(0, 3)), $urandom, $urandom, 1'b0);
            // both instances run a divide in lockstep, so start noise is safe
            if (op[1]) begin
               bus0.start = 1'($urandom_range(0, 1));
               bus1.start = bus0.start;
            end
         end
      end
      drive(1'b0, op, a, b, 1'b0);
      check("lat0", 64'(lat0), 64'(exp0));
      check("lat1", 64'(lat1), 64'(exp1));
      check("busy_cyc0", 64'(bsy0), 64'(exp0));
      check("busy_cyc1", 64'(bsy1), 64'(exp1));
      @(posedge clk); #1;
      check("done_pulse", {62'b0, bus0.done, bus1.done}, 64'd0);
      check("busy_after", {62'b0, bus0.busy, bus1.busy}, 64'd0);
      last_hi = e[2*W-1:W];
      last_lo = e[W-1:0];
   endtask

   initial begin
      int ndone;
      logic [W-1:0] ra, rb;
      logic [1:0]   rop;

      rst = 1'b1;
      drive(1'b0, 2'b00, '0, '0, 1'b0);
      #1;
      check("rst_out0", {bus0.busy, bus0.done, bus0.div_by_zero, bus0.hi, bus0.lo}, 64'd0);
      check("rst_out1", {bus1.busy, bus1.done, bus1.div_by_zero, bus1.hi, bus1.lo}, 64'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(posedge clk); #1;

      run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 1'b0);
      run_op(2'b11, 32'hFFFF_FFFF, 32'h10, 1'b0);
      run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
      run_op(2'b00, 32'hFFFF_FFFD, 32'd5, 1'b0);
      run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
      run_op(2'b10, 32'h1234, 32'd0, 1'b0);
      run_op(2'b11, 32'd5, 32'd0, 1'b0);
      run_op(2'b10, 32'd7, 32'hFFFF_FFFE, 1'b0);

      // annul mid-CALC: result registers must keep the previous values
      drive(1'b1, 2'b11, 32'd100, 32'd7, 1'b0);
      @(posedge clk); #1;
      drive(1'b0, 2'b11, 32'd100, 32'd7, 1'b0);
      repeat (9) begin
         @(posedge clk); #1;
      end
      bus0.annul = 1'b1; bus1.annul = 1'b1;
      @(posedge clk); #1;
      check("annul_busy", {62'b0, bus0.busy, bus1.busy}, 64'd0);
      bus0.annul = 1'b0; bus1.annul = 1'b0;
      ndone = 0;
      repeat (40) begin
         @(posedge clk); #1;
         if (bus0.done || bus1.done) ndone++;
      end
      check("annul_nodone", 64'(ndone), 64'd0);
      check("annul_hold0", {bus0.hi, bus0.lo}, {last_hi, last_lo});
      check("annul_hold1", {bus1.hi, bus1.lo}, {last_hi, last_lo});

      // operands captured at start despite noisy inputs
      run_op(2'b11, 32'd100, 32'd7, 1'b1);

      // start with annul in IDLE is dropped
      drive(1'b1, 2'b10, 32'd50, 32'd3, 1'b1);
      @(posedge clk); #1;
      check("start_annul_busy", {62'b0, bus0.busy, bus1.busy}, 64'd0);
      drive(1'b0, 2'b10, 32'd50, 32'd3, 1'b0);
      @(posedge clk); #1;
      check("start_annul_done", {62'b0, bus0.done, bus1.done}, 64'd0);

      for (int i = 0; i < 24; i++) begin
         rop = 2'($urandom_range(0, 3));
         ra  = $urandom;
         rb  = $urandom;
         case ($urandom_range(0, 5))
            0: rb = '0;
            1: rb = W'($urandom_range(1, 20));
            2: ra = 32'h8000_0000;
            default: ;
         endcase
         run_op(rop, ra, rb, 1'($urandom_range(0, 1)));
      end

      // asynchronous reset mid-CALC
      run_op(2'b11, 32'hDEAD_BEEF, 32'h0000_0123, 1'b0);
      drive(1'b1, 2'b10, 32'h1357_9BDF, 32'd9, 1'b0);
      @(posedge clk); #1;
      drive(1'b0, 2'b10, 32'h1357_9BDF, 32'd9, 1'b0);
      repeat (5) begin
         @(posedge clk); #1;
      end
      #2 rst = 1'b1;
      #1;
      check("arst0", {bus0.busy, bus0.done, bus0.div_by_zero, bus0.hi, bus0.lo}, 64'd0);
      check("arst1", {bus1.busy, bus1.done, bus1.div_by_zero, bus1.hi, bus1.lo}, 64'd0);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk); #1;
      run_op(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
